// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART transmitter and receiver sharing one clock,
// one synchronous active-low reset and one baud divisor. The two halves
// are otherwise independent and may run concurrently (loopback is legal).
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_state;
  logic [CW-1:0] r_tx_cnt,   w_tx_cnt;
  logic [2:0]    r_tx_bit,   w_tx_bit;
  logic [7:0]    r_tx_data,  w_tx_data;
  logic          r_tx_done,  w_tx_done;

  // TX control registers (state, bit timer, bit index, done pulse).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_done  <= w_tx_done;
    end
  end

  // TX byte holding register; only read while in DATA, so it needs no reset.
  always_ff @(posedge clk) begin
    r_tx_data <= w_tx_data;
  end

  // TX next-state logic; line level and busy flag decode straight from state.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_data  = r_tx_data;
    w_tx_done  = 1'b0;
    tx_serial  = 1'b1;
    tx_active  = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt = '0;
        w_tx_bit = '0;
        if (tx_dv) begin
          w_tx_data  = tx_byte;
          w_tx_state = TX_START;
        end
      end
      TX_START: begin
        tx_serial = 1'b0;
        tx_active = 1'b1;
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt   = '0;
          w_tx_state = TX_DATA;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx_serial = r_tx_data[r_tx_bit];
        tx_active = 1'b1;
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state = TX_STOP;
          end else begin
            w_tx_bit = r_tx_bit + 1'b1;
          end
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        tx_active = 1'b1;
        if (r_tx_cnt == CNT_LAST) begin
          // Done pulses in the first IDLE cycle, so a new tx_dv there is accepted.
          w_tx_cnt   = '0;
          w_tx_done  = 1'b1;
          w_tx_state = TX_IDLE;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  assign tx_done = r_tx_done;

  // ---------------- receiver ----------------
  logic          r_rx_sync_p0, r_rx_sync_p1;
  rx_state_t     r_rx_state, w_rx_state;
  logic [CW-1:0] r_rx_cnt,   w_rx_cnt;
  logic [2:0]    r_rx_bit,   w_rx_bit;
  logic [7:0]    r_rx_shift, w_rx_shift;
  logic [7:0]    r_rx_byte,  w_rx_byte;
  logic          r_rx_dv,    w_rx_dv;
  logic          w_rx_line;

  // Two-flop synchroniser for the asynchronous rx pin; resets to idle (high).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_sync_p0 <= 1'b1;
      r_rx_sync_p1 <= 1'b1;
    end else begin
      r_rx_sync_p0 <= rx_serial;
      r_rx_sync_p1 <= r_rx_sync_p0;
    end
  end

  assign w_rx_line = r_rx_sync_p1;

  // RX control registers plus the visible output byte, which must reset to 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= 8'h00;
      r_rx_dv    <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_byte  <= w_rx_byte;
      r_rx_dv    <= w_rx_dv;
    end
  end

  // RX shift register; contents only become visible after a good stop bit.
  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift;
  end

  // RX next-state logic: centre on the start bit, then sample once per bit.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_byte  = r_rx_byte;
    w_rx_dv    = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt = '0;
        w_rx_bit = '0;
        if (!w_rx_line) w_rx_state = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == CNT_MID) begin
          w_rx_cnt   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          w_rx_state = w_rx_line ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt   = '0;
          w_rx_shift = {w_rx_line, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state = RX_STOP;
          end else begin
            w_rx_bit = r_rx_bit + 1'b1;
          end
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt = '0;
          if (w_rx_line) begin
            w_rx_byte  = r_rx_shift;
            w_rx_dv    = 1'b1;
            w_rx_state = RX_IDLE;
          end else begin
            w_rx_state = RX_ERR;
          end
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_ERR: begin
        // Framing error: hold off until the line returns to idle.
        if (w_rx_line) w_rx_state = RX_IDLE;
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  assign rx_dv   = r_rx_dv;
  assign rx_byte = r_rx_byte;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: table-driven and randomized checks of the UART pair,
// with frame levels and received bytes predicted from the 8N1 framing rules.
module tb_uart_transceiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;

  logic       loop_en;
  logic       rx_drv;

  assign rx_serial = loop_en ? tx_serial : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_serial (tx_serial),
    .tx_done   (tx_done),
    .rx_serial (rx_serial),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] rx_q[$];
  int         done_total = 0;

  // Every cycle with rx_dv high records one received byte.
  always @(negedge clk) begin
    if (rx_dv === 1'b1) rx_q.push_back(rx_byte);
    if (tx_done === 1'b1) done_total++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, stop 1 (index = bit period).
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((int'(b) >> i) & 1) != 0;
    f[9] = 1'b1;
    return f;
  endfunction

  // Pulse tx_dv and watch the line mid-bit until tx_done (bounded).
  task automatic send_tx(input logic [7:0] b, output logic [9:0] frame,
                         output int act_cyc, output int done_at);
    frame   = '1;
    act_cyc = 0;
    done_at = -1;
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    for (int k = 0; k < 12 * CPB; k++) begin
      if (tx_active === 1'b1) act_cyc++;
      if ((k % CPB) == CPB / 2 && (k / CPB) < 10) frame[k / CPB] = tx_serial;
      if (tx_done === 1'b1) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rx(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Drive one frame on the RX pin from the bench, then idle for two bits.
  task automatic drive_rx(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic tx_and_check(input string tag, input logic [7:0] b, input logic [9:0] exp_frame);
    logic [9:0] fr;
    int         act;
    int         dn;
    bit         ok;
    rx_q.delete();
    send_tx(b, fr, act, dn);
    check({tag, "_frame"}, fr, exp_frame);
    check({tag, "_active_cycles"}, act, 10 * CPB);
    check({tag, "_done_at"}, dn, 10 * CPB);
    @(negedge clk);
    check({tag, "_done_width"}, tx_done, 1'b0);
    wait_rx(1, 4 * CPB, ok);
    if (ok) check({tag, "_rx_byte"}, rx_q.pop_front(), b);
    else    check({tag, "_rx_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } tx_vec_t;

  tx_vec_t    vecs[5];
  logic [7:0] exp_last;
  logic [7:0] rb;
  bit         ok;
  bit         good;
  int         d0;
  int         nq;

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    resetn  = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    loop_en = 1'b0;
    rx_drv  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tx_serial", tx_serial, 1'b1);
    check("reset_tx_active", tx_active, 1'b0);
    check("reset_tx_done",   tx_done,   1'b0);
    check("reset_rx_dv",     rx_dv,     1'b0);
    check("reset_rx_byte",   rx_byte,   8'h00);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven loopback frames
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) tx_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].frame);

    // Back-to-back 0x3C, 0xFF with an ignored 0x11 strobe while busy
    rx_q.delete();
    d0 = done_total;
    @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'h3C;
    @(negedge clk);
    tx_dv = 1'b0; tx_byte = 8'h00;
    repeat (20) @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'h11;
    @(negedge clk);
    tx_dv = 1'b0; tx_byte = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 12 * CPB; i++) begin
      if (tx_done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_first_done", ok, 1'b1);
    tx_dv = 1'b1; tx_byte = 8'hFF;
    @(negedge clk);
    tx_dv = 1'b0; tx_byte = 8'h00;
    check("b2b_second_active", tx_active, 1'b1);
    check("b2b_second_start_bit", tx_serial, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 12 * CPB; i++) begin
      if (tx_done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_second_done", ok, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    nq = rx_q.size();
    check("b2b_rx_count", nq, 2);
    if (nq > 0) check("b2b_rx_first",  rx_q[0], 8'h3C);
    if (nq > 1) check("b2b_rx_second", rx_q[1], 8'hFF);
    check("b2b_done_count", done_total - d0, 2);
    exp_last = 8'hFF;

    // 3-cycle glitch on an idle RX line
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (2) @(negedge clk);
    rx_q.delete();
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_no_dv", rx_q.size(), 0);
    check("glitch_rx_byte", rx_byte, exp_last);

    // Framing error then a good frame
    drive_rx(8'h55, 1'b0);
    check("frame_err_no_dv", rx_q.size(), 0);
    check("frame_err_rx_byte", rx_byte, exp_last);
    drive_rx(8'h81, 1'b1);
    nq = rx_q.size();
    check("after_err_count", nq, 1);
    if (nq > 0) check("after_err_byte", rx_q.pop_front(), 8'h81);
    check("after_err_rx_byte", rx_byte, 8'h81);
    exp_last = 8'h81;

    // Randomized loopback transmissions
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      tx_and_check($sformatf("rand_tx%0d", i), rb, model_frame(rb));
    end
    exp_last = rb;

    // Randomized bench-driven RX frames, some with a bad stop bit
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      rx_q.delete();
      drive_rx(rb, good);
      if (good) exp_last = rb;
      nq = rx_q.size();
      check($sformatf("rand_rx%0d_count", i), nq, good ? 1 : 0);
      check($sformatf("rand_rx%0d_byte", i), rx_byte, exp_last);
    end

    // Reset in the middle of a TX frame, then a fresh frame
    loop_en = 1'b1;
    rx_q.delete();
    @(negedge clk);
    tx_dv = 1'b1; tx_byte = 8'h00;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_active", tx_active, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_serial", tx_serial, 1'b1);
    check("mid_rst_tx_active", tx_active, 1'b0);
    check("mid_rst_rx_byte",   rx_byte,   8'h00);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("mid_rst_no_rx", rx_q.size(), 0);
    tx_and_check("post_rst", 8'h5A, 10'b1_01011010_0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
